sync_link_ctrl: RTL and testbench

- Supervisory controller that sequences the PCS receive Synchronization block. It drives the block's power_on/reset input and watches code_sync_status.
- Qualifies a stable link, declares link_up, detects acquisition timeouts, and retrains after loss of sync with a back-off.
- Sits between the management/enable logic and Synchronization. link_up feeds the downstream receive and auto-negotiation logic.

---
 rtl/sync_link_ctrl_pkg.sv | 24 ++
 rtl/sync_link_ctrl_sat_counter.sv | 38 +++
 rtl/sync_link_ctrl.sv | 128 ++++++++++++
 tb/tb_sync_link_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_link_ctrl_pkg.sv
// Shared definitions for the PCS synchronization supervisory controller.
package sync_link_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned CNT_W_DEF = 8;

    // One-hot encodings, also exported on ctrl_state for debug.
    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        RESET_SYNC = 6'b000010,
        ACQUIRE    = 6'b000100,
        QUALIFY    = 6'b001000,
        LINK_UP    = 6'b010000,
        BACKOFF    = 6'b100000
    } link_state_e;

    // Saturation value of a counter of the given width (widths up to 32).
    function automatic int unsigned sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/sync_link_ctrl_sat_counter.sv
// Saturating event counter; clear wins over a same-cycle increment.
module sync_sat_counter
    import sync_link_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != SAT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sync_link_ctrl.sv
// Sequences the PCS Synchronization block: reset, acquire, qualify, link up,
// and back-off retraining after loss of sync or acquisition timeout.
module sync_link_ctrl
    import sync_link_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned ACQ_TIMEOUT    = 1024,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned BACKOFF_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             mr_main_reset,
    input  logic             enable,
    input  logic             code_sync_status,
    input  logic             clear_counters,
    output logic             sync_reset,
    output logic             link_up,
    output logic             timeout_err,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [5:0]       ctrl_state
);

    localparam int unsigned TMAX_A = (RST_CYCLES > ACQ_TIMEOUT) ? RST_CYCLES : ACQ_TIMEOUT;
    localparam int unsigned TMAX_B = (STABLE_CYCLES > BACKOFF_CYCLES) ? STABLE_CYCLES : BACKOFF_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int unsigned TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACQ_LAST = TMR_W'(ACQ_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] BO_LAST  = TMR_W'(BACKOFF_CYCLES - 1);

    link_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sync_reset_q, sync_reset_d;
    logic             link_up_q, link_up_d;
    logic             timeout_err_q, timeout_err_d;
    logic             loss_inc, timeout_inc;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + TMR_W'(1);
        timeout_err_d = FALSE;
        loss_inc      = FALSE;
        timeout_inc   = FALSE;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       state_d = RESET_SYNC;
                RESET_SYNC: if (timer_q == RST_LAST) state_d = ACQUIRE;
                ACQUIRE: begin
                    if (code_sync_status) begin
                        state_d = QUALIFY;
                    end else if (timer_q == ACQ_LAST) begin
                        state_d       = BACKOFF;
                        timeout_err_d = TRUE;
                        timeout_inc   = TRUE;
                    end
                end
                QUALIFY: begin
                    if (!code_sync_status) begin
                        state_d = ACQUIRE;
                    end else if (timer_q == STB_LAST) begin
                        state_d = LINK_UP;
                    end
                end
                LINK_UP: begin
                    if (!code_sync_status) begin
                        state_d  = BACKOFF;
                        loss_inc = TRUE;
                    end
                end
                BACKOFF:    if (timer_q == BO_LAST) state_d = ACQUIRE;
                default:    state_d = IDLE;
            endcase
        end

        // Timer only runs in the timed states and restarts on every entry.
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == LINK_UP)) begin
            timer_d = '0;
        end

        sync_reset_d = !((state_d == ACQUIRE) || (state_d == QUALIFY) || (state_d == LINK_UP));
        link_up_d    = (state_d == LINK_UP);
    end

    always_ff @(posedge clk) begin
        if (mr_main_reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            sync_reset_q  <= TRUE;
            link_up_q     <= FALSE;
            timeout_err_q <= FALSE;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sync_reset_q  <= sync_reset_d;
            link_up_q     <= link_up_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    sync_sat_counter #(.CNT_W(CNT_W)) u_loss_cnt (
        .clk   (clk),
        .rst   (mr_main_reset),
        .clear (clear_counters),
        .inc   (loss_inc),
        .count (loss_count)
    );

    sync_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst   (mr_main_reset),
        .clear (clear_counters),
        .inc   (timeout_inc),
        .count (timeout_count)
    );

    assign sync_reset  = sync_reset_q;
    assign link_up     = link_up_q;
    assign timeout_err = timeout_err_q;
    assign ctrl_state  = state_q;

endmodule

// File: tb/tb_sync_link_ctrl.sv
// Directed and randomized bench for sync_link_ctrl against a duration-based reference model.
module tb_sync_link_ctrl;

    localparam int RST = 4;
    localparam int ACQ = 1024;
    localparam int STB = 16;
    localparam int BO  = 64;
    localparam int W   = 8;
    localparam int SAT = 255;

    // One-hot position follows the state order IDLE..BACKOFF.
    localparam logic [5:0] OH_IDLE = 6'b000001;
    localparam logic [5:0] OH_RS   = 6'b000010;
    localparam logic [5:0] OH_ACQ  = 6'b000100;
    localparam logic [5:0] OH_QUAL = 6'b001000;
    localparam logic [5:0] OH_UP   = 6'b010000;

    localparam int PH_IDLE = 0, PH_RESET = 1, PH_ACQ = 2, PH_QUAL = 3, PH_UP = 4, PH_BACK = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         mr_main_reset = 1'b1;
    logic         enable = 1'b0;
    logic         code_sync_status = 1'b0;
    logic         clear_counters = 1'b0;
    logic         sync_reset, link_up, timeout_err;
    logic [W-1:0] loss_count, timeout_count;
    logic [5:0]   ctrl_state;

    int checks = 0;
    int errors = 0;

    // Reference model: current phase, edges spent in it, counters, pulse.
    int m_phase = PH_IDLE;
    int m_elapsed = 0;
    int m_loss = 0;
    int m_to = 0;
    bit m_terr = 1'b0;

    sync_link_ctrl #(
        .RST_CYCLES(RST), .ACQ_TIMEOUT(ACQ), .STABLE_CYCLES(STB),
        .BACKOFF_CYCLES(BO), .CNT_W(W)
    ) dut (
        .clk(clk), .mr_main_reset(mr_main_reset), .enable(enable),
        .code_sync_status(code_sync_status), .clear_counters(clear_counters),
        .sync_reset(sync_reset), .link_up(link_up), .timeout_err(timeout_err),
        .loss_count(loss_count), .timeout_count(timeout_count), .ctrl_state(ctrl_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit st, input bit clr);
        int nxt;
        bit loss_ev, to_ev;
        if (rst) begin
            m_phase = PH_IDLE; m_elapsed = 0; m_loss = 0; m_to = 0; m_terr = 1'b0;
            return;
        end
        nxt = m_phase; loss_ev = 1'b0; to_ev = 1'b0;
        if (!en) nxt = PH_IDLE;
        else begin
            case (m_phase)
                PH_IDLE:  nxt = PH_RESET;
                PH_RESET: if (m_elapsed + 1 >= RST) nxt = PH_ACQ;
                PH_ACQ: begin
                    if (st) nxt = PH_QUAL;
                    else if (m_elapsed + 1 >= ACQ) begin nxt = PH_BACK; to_ev = 1'b1; end
                end
                PH_QUAL: begin
                    if (!st) nxt = PH_ACQ;
                    else if (m_elapsed + 1 >= STB) nxt = PH_UP;
                end
                PH_UP:    if (!st) begin nxt = PH_BACK; loss_ev = 1'b1; end
                default:  if (m_elapsed + 1 >= BO) nxt = PH_ACQ;
            endcase
        end
        m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
        m_phase = nxt;
        m_terr = to_ev;
        if (clr) begin m_loss = 0; m_to = 0; end
        else begin
            if (loss_ev && m_loss < SAT) m_loss++;
            if (to_ev && m_to < SAT) m_to++;
        end
    endtask

    task automatic check_model();
        bit exp_sr;
        exp_sr = (m_phase == PH_IDLE) || (m_phase == PH_RESET) || (m_phase == PH_BACK);
        chk("model_sync_reset", 32'(sync_reset), 32'(exp_sr));
        chk("model_link_up", 32'(link_up), 32'(m_phase == PH_UP));
        chk("model_timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("model_loss_count", 32'(loss_count), 32'(m_loss));
        chk("model_timeout_count", 32'(timeout_count), 32'(m_to));
        chk("model_ctrl_state", 32'(ctrl_state), 32'(1) << m_phase);
    endtask

    task automatic tick(input bit rst, input bit en, input bit st, input bit clr);
        mr_main_reset = rst; enable = en; code_sync_status = st; clear_counters = clr;
        @(posedge clk);
        model_edge(rst, en, st, clr);
        #1;
        check_model();
    endtask

    task automatic run_until_up(input int budget, output int qual_ticks);
        bit up;
        up = 1'b0; qual_ticks = 0;
        for (int i = 0; i < budget && !up; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            if (ctrl_state === OH_QUAL) qual_ticks++;
            if (link_up === 1'b1) up = 1'b1;
        end
        chk("link_up_reached", 32'(up), 32'd1);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int q, rs, bo, acq_ticks, saved;
        bit seen, st;

        // Reset state
        do_reset();
        chk("rst_sync_reset", 32'(sync_reset), 32'd1);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_loss", 32'(loss_count), 32'd0);
        chk("rst_state", 32'(ctrl_state), 32'(OH_IDLE));

        // Bring-up with status high from cycle 6
        rs = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            if (ctrl_state === OH_RS && sync_reset === 1'b1) rs++;
        end
        chk("reset_sync_len", 32'(rs), RST);
        chk("acquire_sync_released", 32'(sync_reset), 32'd0);
        run_until_up(60, q);
        chk("qualify_len", 32'(q), STB);
        chk("bringup_loss", 32'(loss_count), 32'd0);

        // Single-cycle loss of sync
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("loss_link_down", 32'(link_up), 32'd0);
        chk("loss_count_1", 32'(loss_count), 32'd1);
        bo = (sync_reset === 1'b1) ? 1 : 0;
        for (int n = 0; n < 100 && sync_reset === 1'b1; n++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            if (sync_reset === 1'b1) bo++;
        end
        chk("backoff_len", 32'(bo), BO);
        chk("backoff_to_acquire", 32'(ctrl_state), 32'(OH_ACQ));
        run_until_up(40, q);
        chk("requalify_len", 32'(q), STB);

        // Stuck-low status: three acquisition timeouts
        do_reset();
        for (int r = 0; r < 3; r++) begin
            acq_ticks = 0; seen = 1'b0;
            for (int i = 0; i < 1500 && !seen; i++) begin
                tick(1'b0, 1'b1, 1'b0, 1'b0);
                if (ctrl_state === OH_ACQ) acq_ticks++;
                if (timeout_err === 1'b1) seen = 1'b1;
            end
            chk("timeout_seen", 32'(seen), 32'd1);
            chk("acquire_len", 32'(acq_ticks), ACQ);
            chk("timeout_count_step", 32'(timeout_count), 32'(r + 1));
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            chk("timeout_single_pulse", 32'(timeout_err), 32'd0);
        end
        chk("timeout_count_3", 32'(timeout_count), 32'd3);

        // Glitch during qualification
        do_reset();
        for (int i = 0; i < 20 && ctrl_state !== OH_ACQ; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("glitch_in_qualify", 32'(ctrl_state), 32'(OH_QUAL));
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("glitch_to_acquire", 32'(ctrl_state), 32'(OH_ACQ));
        chk("glitch_no_loss", 32'(loss_count), 32'd0);
        run_until_up(40, q);
        chk("glitch_full_requalify", 32'(q), STB);

        // 300 losses saturate; clear beats a same-cycle loss
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            run_until_up(200, q);
        end
        chk("loss_saturated", 32'(loss_count), SAT);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_beats_loss", 32'(loss_count), 32'd0);
        run_until_up(200, q);

        // enable=0 mid-LINK_UP keeps counters
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_up(200, q);
        saved = int'(loss_count);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dis_state", 32'(ctrl_state), 32'(OH_IDLE));
        chk("dis_sync_reset", 32'(sync_reset), 32'd1);
        chk("dis_link_up", 32'(link_up), 32'd0);
        chk("dis_keeps_loss", 32'(loss_count), 32'd1);
        chk("dis_loss_unchanged", 32'(loss_count), 32'(saved));

        // Reset mid-LINK_UP clears counters
        run_until_up(60, q);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mrst_state", 32'(ctrl_state), 32'(OH_IDLE));
        chk("mrst_sync_reset", 32'(sync_reset), 32'd1);
        chk("mrst_link_up", 32'(link_up), 32'd0);
        chk("mrst_loss", 32'(loss_count), 32'd0);
        chk("mrst_timeout", 32'(timeout_count), 32'd0);

        // Randomized traffic against the model
        do_reset();
        st = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) st = ~st;
            tick($urandom_range(0, 2999) == 0, $urandom_range(0, 299) != 0, st,
                 $urandom_range(0, 499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
